// File: rtl/tvip_axi_burst_address_generator.sv
// tvip_axi_burst_address_generator
// Turns one AXI4 burst command into a stream of per-beat addresses, byte-lane
// strobes, beat indices and last flags, one beat per valid/ready handshake.
// Commands that break AXI4 burst legality rules are consumed without issuing
// any beat and are flagged with a one-cycle cmd_error pulse.

module tvip_axi_burst_address_generator #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  // Command side
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0]   cmd_address,
  input  logic [7:0]                 cmd_length,
  input  logic [2:0]                 cmd_size,
  input  logic [1:0]                 cmd_burst,
  output logic                       cmd_error,
  // Beat side
  output logic                       beat_valid,
  input  logic                       beat_ready,
  output logic [ADDRESS_WIDTH-1:0]   beat_address,
  output logic [DATA_WIDTH/8-1:0]    beat_strobe,
  output logic [7:0]                 beat_index,
  output logic                       beat_last
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  // Largest encoded size the bus can carry (log2 of the strobe width).
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STROBE_WIDTH));

  // Address bits that select a byte inside a 4 KB page.
  localparam int PAGE_BITS = 12;

  localparam logic [1:0] BURST_FIXED    = 2'b00;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] BURST_WRAP     = 2'b10;
  localparam logic [1:0] BURST_RESERVED = 2'b11;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [ADDRESS_WIDTH-1:0] ONE       = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(STROBE_WIDTH - 1);

  // Active lanes: from the byte offset of addr up to the end of the
  // size-aligned container holding it. A size wider than the bus never
  // reaches this function because such commands are rejected.
  function automatic logic [STROBE_WIDTH-1:0] lane_strobe(
    input logic [ADDRESS_WIDTH-1:0] addr,
    input logic [2:0]               size
  );
    logic [ADDRESS_WIDTH-1:0] bytes;
    logic [ADDRESS_WIDTH-1:0] lo;
    logic [ADDRESS_WIDTH-1:0] hi;
    logic [STROBE_WIDTH-1:0]  mask;
    bytes = ONE << size;
    lo    = addr & LANE_MASK;
    hi    = ((addr & ~(bytes - ONE)) & LANE_MASK) + bytes - ONE;
    mask  = '0;
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      mask[i] = (ADDRESS_WIDTH'(i) >= lo) && (ADDRESS_WIDTH'(i) <= hi);
    end
    return mask;
  endfunction

  // ---------------------------------------------------------------------------
  // State and latched command
  // ---------------------------------------------------------------------------
  logic [0:0]               state;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic [7:0]               length_q;
  logic [ADDRESS_WIDTH-1:0] wrap_base_q;
  logic [ADDRESS_WIDTH-1:0] wrap_end_q;

  logic cmd_accept;

  assign cmd_ready  = (state == IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;

  // ---------------------------------------------------------------------------
  // Command screening
  // ---------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] cmd_bytes;
  logic [ADDRESS_WIDTH-1:0] cmd_total;
  logic [ADDRESS_WIDTH-1:0] cmd_aligned;
  logic [ADDRESS_WIDTH-1:0] cmd_end;
  logic [ADDRESS_WIDTH-1:0] cmd_wrap_base;
  logic                     size_too_big;
  logic                     fixed_too_long;
  logic                     wrap_bad_length;
  logic                     wrap_misaligned;
  logic                     incr_page_cross;
  logic                     cmd_illegal;

  // Decode the presented command into its legality flags and wrap window.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    cmd_bytes       = ONE << cmd_size;
    cmd_total       = ADDRESS_WIDTH'(({1'b0, cmd_length} + 9'd1)) << cmd_size;
    cmd_aligned     = cmd_address & ~(cmd_bytes - ONE);
    cmd_end         = cmd_aligned + cmd_total - ONE;
    // For a legal WRAP the total is a power of two, so masking by total-1
    // clears exactly log2(total) low bits.
    cmd_wrap_base   = cmd_address & ~(cmd_total - ONE);

    size_too_big    = (cmd_size > MAX_SIZE);
    fixed_too_long  = (cmd_burst == BURST_FIXED) && (cmd_length > 8'd15);
    wrap_bad_length = (cmd_burst == BURST_WRAP) &&
                      !(cmd_length inside {8'd1, 8'd3, 8'd7, 8'd15});
    wrap_misaligned = (cmd_burst == BURST_WRAP) &&
                      (|(cmd_address & (cmd_bytes - ONE)));
    // Any differing bit above the page offset means the last byte sits in
    // another 4 KB page (including wrap-around at the top of the space).
    incr_page_cross = (cmd_burst == BURST_INCR) &&
                      (|((cmd_end ^ cmd_address) >> PAGE_BITS));

    cmd_illegal     = (cmd_burst == BURST_RESERVED) || size_too_big ||
                      fixed_too_long || wrap_bad_length || wrap_misaligned ||
                      incr_page_cross;
  end

  // ---------------------------------------------------------------------------
  // Next-beat computation
  // ---------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] beat_bytes;
  logic [ADDRESS_WIDTH-1:0] incr_address;
  logic [ADDRESS_WIDTH-1:0] next_address;
  logic [7:0]               next_index;
  logic                     next_last;

  // Address, index and last flag of the beat following the current one.
  always_comb begin
    beat_bytes   = ONE << size_q;
    incr_address = beat_address + beat_bytes;
    next_index   = beat_index + 8'd1;
    next_last    = (next_index == length_q);
    next_address = beat_address;
    case (burst_q)
      BURST_FIXED: next_address = beat_address;
      BURST_INCR:  next_address = (beat_address & ~(beat_bytes - ONE)) + beat_bytes;
      BURST_WRAP:  next_address = (incr_address == wrap_end_q) ? wrap_base_q
                                                              : incr_address;
      default:     next_address = beat_address;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // Accept and screen commands, then step through beats on each handshake.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state        <= IDLE;
      size_q       <= '0;
      burst_q      <= '0;
      length_q     <= '0;
      wrap_base_q  <= '0;
      wrap_end_q   <= '0;
      cmd_error    <= 1'b0;
      beat_valid   <= 1'b0;
      beat_address <= '0;
      beat_strobe  <= '0;
      beat_index   <= '0;
      beat_last    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cmd_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            if (cmd_illegal) begin
              cmd_error <= 1'b1;
            end else begin
              state        <= BURST;
              size_q       <= cmd_size;
              burst_q      <= cmd_burst;
              length_q     <= cmd_length;
              wrap_base_q  <= cmd_wrap_base;
              wrap_end_q   <= cmd_wrap_base + cmd_total;
              beat_valid   <= 1'b1;
              beat_address <= cmd_address;
              beat_strobe  <= lane_strobe(cmd_address, cmd_size);
              beat_index   <= 8'd0;
              beat_last    <= (cmd_length == 8'd0);
            end
          end
        end
        BURST: begin
          if (beat_valid && beat_ready) begin
            if (beat_last) begin
              state      <= IDLE;
              beat_valid <= 1'b0;
              beat_last  <= 1'b0;
            end else begin
              beat_address <= next_address;
              beat_strobe  <= lane_strobe(next_address, size_q);
              beat_index   <= next_index;
              beat_last    <= next_last;
            end
          end
        end
        default: begin
          state      <= IDLE;
          beat_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tvip_axi_burst_address_generator.md
# tvip_axi_burst_address_generator

Sequences one AXI4 burst command (start address, encoded length, size, burst type) into a stream of per-beat addresses, byte-lane strobes and last flags, one beat per valid/ready handshake. It sits between the address-channel front end of the master/slave agents and their data-channel beat engines. It also screens commands against AXI4 burst legality rules before any beat is issued.

## Interface
- ADDRESS_WIDTH, 64, address width in bits (≥ 13)
- DATA_WIDTH, 32, data bus width in bits (power of two, 8..1024); STROBE_WIDTH = DATA_WIDTH/8

- aclk  input  1  clock
- areset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command valid
- cmd_ready  output  1  command accept; equals (state == IDLE)
- cmd_address  input  ADDRESS_WIDTH  burst start address
- cmd_length  input  8  encoded burst length (beats − 1)
- cmd_size  input  3  encoded burst size (bytes = 1 << cmd_size)
- cmd_burst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- cmd_error  output  1  one-cycle pulse: the last accepted command was illegal
- beat_valid  output  1  beat valid
- beat_ready  input  1  beat accept
- beat_address  output  ADDRESS_WIDTH  address of the current beat
- beat_strobe  output  STROBE_WIDTH  active byte lanes of the current beat
- beat_index  output  8  beat number, starting at 0
- beat_last  output  1  final beat of the burst

## Operation
- States:
  - IDLE: cmd_ready = 1.
  - BURST: cmd_ready = 0.
- Command acceptance: the command is accepted on a cycle where cmd_valid && cmd_ready. It is latched and checked in that cycle.
- Illegal command (any one of the following):
  - cmd_burst = 11.
  - Size bytes > STROBE_WIDTH.
  - FIXED with cmd_length > 15.
  - WRAP with cmd_length not in {1, 3, 7, 15}.
  - WRAP with cmd_address not aligned to size.
  - INCR where aligned_start + bytes × (cmd_length + 1) − 1 lies in a different 4 KB page than cmd_address.
- Handling an illegal command: the command is consumed. cmd_error pulses the next cycle. No beats are issued. State stays IDLE.
- Handling a legal command: state → BURST. Beat 0 is presented with beat_address = cmd_address.
- Definitions:
  - aligned(a) = a with the low cmd_size bits cleared.
  - total = bytes × (cmd_length + 1).
  - wrap_base = cmd_address with the low log2(total) bits cleared.
- Next-beat address:
  - FIXED: unchanged.
  - INCR: aligned(prev) + bytes.
  - WRAP: prev + bytes; if the result equals wrap_base + total, it becomes wrap_base.
- Strobe: lanes from beat_address mod STROBE_WIDTH up to (aligned(beat_address) mod STROBE_WIDTH) + bytes − 1 are set; all other lanes are clear. An unaligned first INCR/FIXED beat therefore has its low lanes clear.
- beat_last = (beat_index == latched cmd_length).
- Address arithmetic is modulo 2^ADDRESS_WIDTH. beat_index counts to at most 255.

## Timing
- Reset values: state IDLE, cmd_ready 1, cmd_error 0, beat_valid 0, beat_address 0, beat_strobe 0, beat_index 0, beat_last 0.
- Reset assertion takes effect immediately (asynchronous), including mid-burst. The burst is abandoned with no further beats.
- Command latency: a legal command accepted at edge N drives beat_valid = 1 from edge N (registered outputs), i.e. visible in cycle N+1.
- Beat outputs are registered. They are held stable while beat_valid && !beat_ready.
- Each beat handshake advances to the next beat in the following cycle. There are no bubbles between beats.
- The handshake on the beat with beat_last = 1 returns the block to IDLE. beat_valid drops and cmd_ready rises in the next cycle, so there is one idle cycle minimum between bursts.
- cmd_error is registered and is high exactly the cycle after the illegal command's acceptance. Back-to-back illegal commands each produce a pulse.
- cmd_valid during BURST is ignored. The command must be held by the source per the valid/ready rules.

## Test plan
- INCR, address 0x1002, cmd_length 3, size 4 B, beat_ready = 1:
  - Addresses 0x1002, 0x1004, 0x1008, 0x100C.
  - Strobes 0xC, 0xF, 0xF, 0xF.
  - beat_last on index 3 only.
  - cmd_ready high again 1 cycle after the last handshake.
- WRAP, address 0x38, cmd_length 3, size 4 B:
  - Addresses 0x38, 0x3C, 0x30, 0x34.
  - Strobes 0xF on every beat.
- FIXED, address 0x101, cmd_length 2, size 1 B: three beats, each at 0x101 with strobe 0x2.
- Illegal commands, each → cmd_error pulse of 1 cycle, beat_valid stays 0, cmd_ready stays 1:
  - INCR at 0xFF8, cmd_length 3, size 4 B (page crossing).
  - WRAP with cmd_length 2.
  - Size 8 B on the 32-bit bus.
  - cmd_burst = 11.
- Backpressure: INCR at 0x0, cmd_length 7, beat_ready held low 5 cycles at beat 2:
  - beat_address 0x8, beat_strobe 0xF and beat_index 2 stay stable throughout.
  - cmd_ready stays 0 while a new cmd_valid is held.
  - The burst completes 8 beats, then the held command is accepted.
- Reset mid-burst: areset_n low during beat 2 of an INCR 8-beat burst:
  - beat_valid drops immediately and all outputs take their reset values.
  - After release, a new INCR at 0x2000, cmd_length 0 yields a single beat at 0x2000 with beat_last = 1.
